// File: rtl/rocc_acc_pkg.sv
// Shared types and constants for the rocc_acc_bank RoCC accelerator.
package rocc_acc_pkg;

  typedef enum logic [2:0] {
    OP_SET   = 3'd0,
    OP_READ  = 3'd1,
    OP_ADD   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_CLEAR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_RESP
  } state_e;

  localparam logic [4:0] M_XRD = 5'b00000;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rocc_acc_bank_if.sv
// RoCC command/response, D$ memory port and status signals between core and rocc_acc_bank.
interface rocc_acc_bank_if #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned COREMAXADDRBITS = 40,
  parameter int unsigned DCACHETAGBITS   = 8,
  parameter int unsigned M_SZ            = 5,
  parameter int unsigned SIZE_W          = 2
);
  logic                       rocc_cmd_ready;
  logic                       rocc_cmd_valid;
  logic [6:0]                 rocc_cmd_bits_inst_funct;
  logic [4:0]                 rocc_cmd_bits_inst_rd;
  logic                       rocc_cmd_bits_inst_xd;
  logic [XLEN-1:0]            rocc_cmd_bits_rs1;
  logic [XLEN-1:0]            rocc_cmd_bits_rs2;
  logic                       rocc_resp_ready;
  logic                       rocc_resp_valid;
  logic [4:0]                 rocc_resp_bits_rd;
  logic [XLEN-1:0]            rocc_resp_bits_data;
  logic                       rocc_mem_req_ready;
  logic                       rocc_mem_req_valid;
  logic [COREMAXADDRBITS-1:0] rocc_mem_req_bits_addr;
  logic [DCACHETAGBITS-1:0]   rocc_mem_req_bits_tag;
  logic [M_SZ-1:0]            rocc_mem_req_bits_cmd;
  logic [SIZE_W-1:0]          rocc_mem_req_bits_size;
  logic                       rocc_mem_req_bits_signed;
  logic                       rocc_mem_req_bits_phys;
  logic                       rocc_mem_req_bits_no_alloc;
  logic                       rocc_mem_req_bits_no_xcpt;
  logic [XLEN-1:0]            rocc_mem_req_bits_data;
  logic [XLEN/8-1:0]          rocc_mem_req_bits_mask;
  logic                       rocc_mem_s1_kill;
  logic                       rocc_mem_s2_kill;
  logic                       rocc_mem_s2_nack;
  logic                       rocc_mem_resp_valid;
  logic [DCACHETAGBITS-1:0]   rocc_mem_resp_bits_tag;
  logic [XLEN-1:0]            rocc_mem_resp_bits_data;
  logic                       rocc_busy;
  logic                       rocc_interrupt;
  logic                       rocc_exception;

  modport slave (
    input  rocc_cmd_valid, rocc_cmd_bits_inst_funct, rocc_cmd_bits_inst_rd,
           rocc_cmd_bits_inst_xd, rocc_cmd_bits_rs1, rocc_cmd_bits_rs2,
           rocc_resp_ready, rocc_mem_req_ready, rocc_mem_s2_nack,
           rocc_mem_resp_valid, rocc_mem_resp_bits_tag, rocc_mem_resp_bits_data,
           rocc_exception,
    output rocc_cmd_ready, rocc_resp_valid, rocc_resp_bits_rd, rocc_resp_bits_data,
           rocc_mem_req_valid, rocc_mem_req_bits_addr, rocc_mem_req_bits_tag,
           rocc_mem_req_bits_cmd, rocc_mem_req_bits_size, rocc_mem_req_bits_signed,
           rocc_mem_req_bits_phys, rocc_mem_req_bits_no_alloc, rocc_mem_req_bits_no_xcpt,
           rocc_mem_req_bits_data, rocc_mem_req_bits_mask, rocc_mem_s1_kill,
           rocc_mem_s2_kill, rocc_busy, rocc_interrupt
  );

  modport master (
    output rocc_cmd_valid, rocc_cmd_bits_inst_funct, rocc_cmd_bits_inst_rd,
           rocc_cmd_bits_inst_xd, rocc_cmd_bits_rs1, rocc_cmd_bits_rs2,
           rocc_resp_ready, rocc_mem_req_ready, rocc_mem_s2_nack,
           rocc_mem_resp_valid, rocc_mem_resp_bits_tag, rocc_mem_resp_bits_data,
           rocc_exception,
    input  rocc_cmd_ready, rocc_resp_valid, rocc_resp_bits_rd, rocc_resp_bits_data,
           rocc_mem_req_valid, rocc_mem_req_bits_addr, rocc_mem_req_bits_tag,
           rocc_mem_req_bits_cmd, rocc_mem_req_bits_size, rocc_mem_req_bits_signed,
           rocc_mem_req_bits_phys, rocc_mem_req_bits_no_alloc, rocc_mem_req_bits_no_xcpt,
           rocc_mem_req_bits_data, rocc_mem_req_bits_mask, rocc_mem_s1_kill,
           rocc_mem_s2_kill, rocc_busy, rocc_interrupt
  );
endinterface

// File: rtl/rocc_acc_regfile.sv
// Accumulator storage: one write port, one async read port, clear-all.
// ROCC_ACC_OVF_IRQ_EN adds sticky per-accumulator overflow flags ORed into irq_o.
import rocc_acc_pkg::*;

module rocc_acc_regfile #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_ACC = 4,
  parameter int unsigned IDXW    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic            wr_ovf_i,
  input  logic            wr_clr_flag_i,
  input  logic            clear_all_i,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            irq_o
);
  logic [XLEN-1:0] acc_q [NUM_ACC];

  always_ff @(posedge clock) begin
    if (reset || clear_all_i) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else if (wr_en_i) begin
      acc_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = acc_q[rd_idx_i];

`ifdef ROCC_ACC_OVF_IRQ_EN
  logic [NUM_ACC-1:0] ovf_q;

  // A SET write clears the flag; ADD/LOAD writes only ever set it.
  always_ff @(posedge clock) begin
    if (reset || clear_all_i) begin
      ovf_q <= '0;
    end else if (wr_en_i) begin
      if (wr_clr_flag_i)  ovf_q[wr_idx_i] <= 1'b0;
      else if (wr_ovf_i)  ovf_q[wr_idx_i] <= 1'b1;
    end
  end

  assign irq_o = |ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = wr_ovf_i ^ wr_clr_flag_i;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: rtl/rocc_acc_bank.sv
// RoCC accelerator: NUM_ACC accumulators with SET/READ/ADD/LOAD/CLEAR and a D$ load path.
// Optional overflow interrupt is enabled by defining ROCC_ACC_OVF_IRQ_EN.
import rocc_acc_pkg::*;

module rocc_acc_bank #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned NUM_ACC         = 4,
  parameter int unsigned COREMAXADDRBITS = 40,
  parameter int unsigned DCACHETAGBITS   = 8,
  parameter int unsigned M_SZ            = 5,
  parameter int unsigned SIZE_W          = 2
) (
  input  logic           clock,
  input  logic           reset,
  rocc_acc_bank_if.slave io
);
  localparam int unsigned       IDXW     = idx_w(NUM_ACC);
  localparam logic [SIZE_W-1:0] MEM_SIZE = SIZE_W'($clog2(XLEN/8));

  state_e                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [4:0]                 rd_q, rd_d;
  logic                       xd_q, xd_d;
  logic [COREMAXADDRBITS-1:0] addr_q, addr_d;
  logic [XLEN-1:0]            data_q, data_d;

  logic [IDXW-1:0] cmd_idx, acc_idx;
  logic [XLEN-1:0] acc_rd, add_a, add_b, wr_data;
  logic [XLEN:0]   sum1, sum2;
  logic            wr_en, wr_ovf, wr_clr_flag, clear_all, mem_hit, irq;
  logic            unused_funct;

  // One shared adder: command operands in IDLE, load data while waiting on the D$.
  assign cmd_idx = io.rocc_cmd_bits_inst_funct[3 +: IDXW];
  assign acc_idx = (state_q == ST_IDLE) ? cmd_idx : idx_q;
  assign add_a   = (state_q == ST_IDLE) ? io.rocc_cmd_bits_rs1 : io.rocc_mem_resp_bits_data;
  assign add_b   = (state_q == ST_IDLE) ? io.rocc_cmd_bits_rs2 : '0;
  assign sum1    = {1'b0, acc_rd} + {1'b0, add_a};
  assign sum2    = {1'b0, sum1[XLEN-1:0]} + {1'b0, add_b};
  assign mem_hit = io.rocc_mem_resp_valid && (io.rocc_mem_resp_bits_tag == '0);
  assign unused_funct = ^io.rocc_cmd_bits_inst_funct;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    xd_d        = xd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en       = 1'b0;
    wr_data     = sum2[XLEN-1:0];
    wr_ovf      = sum1[XLEN] | sum2[XLEN];
    wr_clr_flag = 1'b0;
    clear_all   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.rocc_cmd_valid) begin
          idx_d   = cmd_idx;
          rd_d    = io.rocc_cmd_bits_inst_rd;
          xd_d    = io.rocc_cmd_bits_inst_xd;
          state_d = io.rocc_cmd_bits_inst_xd ? ST_RESP : ST_IDLE;
          case (io.rocc_cmd_bits_inst_funct[2:0])
            OP_SET: begin
              wr_en       = 1'b1;
              wr_data     = io.rocc_cmd_bits_rs1;
              wr_clr_flag = 1'b1;
              data_d      = io.rocc_cmd_bits_rs1;
            end
            OP_READ: data_d = acc_rd;
            OP_ADD: begin
              wr_en  = 1'b1;
              data_d = sum2[XLEN-1:0];
            end
            OP_LOAD: begin
              addr_d  = io.rocc_cmd_bits_rs1[COREMAXADDRBITS-1:0];
              state_d = ST_MEM_REQ;
            end
            OP_CLEAR: begin
              clear_all = 1'b1;
              data_d    = '0;
            end
            default: data_d = '0;
          endcase
        end
      end
      ST_MEM_REQ: if (io.rocc_mem_req_ready) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (mem_hit) begin
          wr_en   = 1'b1;
          data_d  = sum2[XLEN-1:0];
          state_d = xd_q ? ST_RESP : ST_IDLE;
        end else if (io.rocc_mem_s2_nack) begin
          state_d = ST_MEM_REQ;
        end
      end
      ST_RESP: if (io.rocc_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && io.rocc_exception) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rd_q    <= '0;
      xd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      xd_q    <= xd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  rocc_acc_regfile #(
    .XLEN    (XLEN),
    .NUM_ACC (NUM_ACC),
    .IDXW    (IDXW)
  ) u_regfile (
    .clock         (clock),
    .reset         (reset),
    .wr_en_i       (wr_en),
    .wr_idx_i      (acc_idx),
    .wr_data_i     (wr_data),
    .wr_ovf_i      (wr_ovf),
    .wr_clr_flag_i (wr_clr_flag),
    .clear_all_i   (clear_all),
    .rd_idx_i      (acc_idx),
    .rd_data_o     (acc_rd),
    .irq_o         (irq)
  );

  assign io.rocc_cmd_ready             = (state_q == ST_IDLE);
  assign io.rocc_resp_valid            = (state_q == ST_RESP);
  assign io.rocc_resp_bits_rd          = rd_q;
  assign io.rocc_resp_bits_data        = data_q;
  assign io.rocc_mem_req_valid         = (state_q == ST_MEM_REQ);
  assign io.rocc_mem_req_bits_addr     = addr_q;
  assign io.rocc_mem_req_bits_tag      = '0;
  assign io.rocc_mem_req_bits_cmd      = M_SZ'(M_XRD);
  assign io.rocc_mem_req_bits_size     = MEM_SIZE;
  assign io.rocc_mem_req_bits_signed   = 1'b0;
  assign io.rocc_mem_req_bits_phys     = 1'b0;
  assign io.rocc_mem_req_bits_no_alloc = 1'b0;
  assign io.rocc_mem_req_bits_no_xcpt  = 1'b0;
  assign io.rocc_mem_req_bits_data     = '0;
  assign io.rocc_mem_req_bits_mask     = '0;
  assign io.rocc_mem_s1_kill           = 1'b0;
  assign io.rocc_mem_s2_kill           = 1'b0;
  assign io.rocc_busy                  = (state_q != ST_IDLE);
  assign io.rocc_interrupt             = irq;

endmodule

// File: tb/tb_rocc_acc_bank.sv
// Bench for rocc_acc_bank: directed scenarios plus randomized commands against a reference model.
module tb_rocc_acc_bank;
  localparam int unsigned XLEN = 64, NUM_ACC = 4, CAB = 40, TAGB = 8, MSZ = 5, SZW = 2;
  localparam logic [2:0] C_SET = 3'd0, C_READ = 3'd1, C_ADD = 3'd2, C_LOAD = 3'd3, C_CLEAR = 3'd4;
  localparam int unsigned TMO = 100;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0]        ref_acc [NUM_ACC];
  logic [NUM_ACC-1:0] ref_ovf;
  logic [63:0]        mem [logic [39:0]];

  rocc_acc_bank_if #(.XLEN(XLEN), .COREMAXADDRBITS(CAB), .DCACHETAGBITS(TAGB),
                     .M_SZ(MSZ), .SIZE_W(SZW)) bus ();

  rocc_acc_bank #(.XLEN(XLEN), .NUM_ACC(NUM_ACC), .COREMAXADDRBITS(CAB),
                  .DCACHETAGBITS(TAGB), .M_SZ(MSZ), .SIZE_W(SZW)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < int'(NUM_ACC); i++) ref_acc[i] = '0;
    ref_ovf = '0;
  endfunction

  function automatic logic [63:0] mem_lookup(input logic [39:0] a);
    if (!mem.exists(a)) mem[a] = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
    return mem[a];
  endfunction

  // Wide arithmetic: any sum at or above 2^64 is an overflow.
  function automatic logic [63:0] model_exec(input logic [2:0] op, input int unsigned idx,
                                             input logic [63:0] rs1, input logic [63:0] rs2,
                                             input logic [63:0] memd);
    logic [65:0] full;
    case (op)
      C_SET: begin ref_acc[idx] = rs1; ref_ovf[idx] = 1'b0; return rs1; end
      C_READ: return ref_acc[idx];
      C_ADD, C_LOAD: begin
        full = (op == C_ADD) ? 66'(ref_acc[idx]) + 66'(rs1) + 66'(rs2) : 66'(ref_acc[idx]) + 66'(memd);
        ref_acc[idx] = full[63:0];
        if (full[65:64] != 2'b00) ref_ovf[idx] = 1'b1;
        return full[63:0];
      end
      C_CLEAR: begin model_reset(); return '0; end
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_irq();
`ifdef ROCC_ACC_OVF_IRQ_EN
    return |ref_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] rnd64();
    return ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] fhi, input logic [4:0] rd,
                       input logic xd, input logic [63:0] rs1, input logic [63:0] rs2);
    int unsigned n = 0;
    bus.rocc_cmd_valid = 1'b1;
    bus.rocc_cmd_bits_inst_funct = {fhi, op};
    bus.rocc_cmd_bits_inst_rd = rd;
    bus.rocc_cmd_bits_inst_xd = xd;
    bus.rocc_cmd_bits_rs1 = rs1;
    bus.rocc_cmd_bits_rs2 = rs2;
    while (bus.rocc_cmd_ready !== 1'b1 && n < TMO) begin tick(); n++; end
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1 within %0d cycles", bus.rocc_cmd_ready, TMO);
    end
    tick();
    bus.rocc_cmd_valid = 1'b0;
  endtask

  task automatic get_resp(input int unsigned hold, output logic [4:0] rd, output logic [63:0] data);
    int unsigned n = 0;
    while (bus.rocc_resp_valid !== 1'b1 && n < TMO) begin tick(); n++; end
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL resp_wait: resp_valid=%b, required 1 within %0d cycles", bus.rocc_resp_valid, TMO);
    end
    rd = bus.rocc_resp_bits_rd;
    data = bus.rocc_resp_bits_data;
    repeat (hold) tick();
    bus.rocc_resp_ready = 1'b1;
    tick();
    bus.rocc_resp_ready = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (bus.rocc_mem_req_valid !== 1'b1 && n < TMO) begin tick(); n++; end
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL %s: mem_req_valid=%b, required 1 within %0d cycles", tag, bus.rocc_mem_req_valid, TMO);
    end
  endtask

  // D$ model: accept request, optional s2 nack two cycles after the fire, then reply with tag 0.
  task automatic serve_mem(input logic nack, input int unsigned lat, output logic [39:0] addr);
    wait_req("mem_req_wait");
    addr = bus.rocc_mem_req_bits_addr;
    bus.rocc_mem_req_ready = 1'b1;
    tick();
    bus.rocc_mem_req_ready = 1'b0;
    if (nack) begin
      tick();
      bus.rocc_mem_s2_nack = 1'b1;
      tick();
      bus.rocc_mem_s2_nack = 1'b0;
      wait_req("mem_req_replay");
      addr = bus.rocc_mem_req_bits_addr;
      bus.rocc_mem_req_ready = 1'b1;
      tick();
      bus.rocc_mem_req_ready = 1'b0;
    end
    repeat (lat) tick();
    bus.rocc_mem_resp_valid = 1'b1;
    bus.rocc_mem_resp_bits_tag = '0;
    bus.rocc_mem_resp_bits_data = mem_lookup(addr);
    tick();
    bus.rocc_mem_resp_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.rocc_cmd_ready, bus.rocc_resp_valid, bus.rocc_mem_req_valid, bus.rocc_busy, bus.rocc_interrupt} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: ready/resp/req/busy/irq=%b, required 10000",
               {bus.rocc_cmd_ready, bus.rocc_resp_valid, bus.rocc_mem_req_valid, bus.rocc_busy, bus.rocc_interrupt});
    end
    checks++;
    if ({bus.rocc_mem_s1_kill, bus.rocc_mem_s2_kill, bus.rocc_mem_req_bits_signed, bus.rocc_mem_req_bits_phys,
         bus.rocc_mem_req_bits_no_alloc, bus.rocc_mem_req_bits_no_xcpt, bus.rocc_mem_req_bits_mask,
         bus.rocc_mem_req_bits_data} !== '0) begin
      errors++;
      $display("FAIL tied_zero: kill/flags/mask/data not all zero, mask=%h data=%h",
               bus.rocc_mem_req_bits_mask, bus.rocc_mem_req_bits_data);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_set_add();
    logic [63:0] exp, d;
    logic [4:0]  r;
    issue(C_SET, 4'd1, 5'd0, 1'b0, 64'd5, 64'd0);
    exp = model_exec(C_SET, 1, 64'd5, 64'd0, 64'd0);
    issue(C_ADD, 4'd1, 5'd7, 1'b1, 64'd3, 64'd4);
    exp = model_exec(C_ADD, 1, 64'd3, 64'd4, 64'd0);
    checks++;
    if (bus.rocc_resp_valid !== 1'b1 || bus.rocc_resp_bits_rd !== 5'd7 || bus.rocc_resp_bits_data !== exp) begin
      errors++;
      $display("FAIL add_resp: valid=%b rd=%0d data=%h, required 1 rd=7 data=%h",
               bus.rocc_resp_valid, bus.rocc_resp_bits_rd, bus.rocc_resp_bits_data, exp);
    end
    get_resp(0, r, d);
    issue(C_READ, 4'd1, 5'd2, 1'b1, 64'd0, 64'd0);
    exp = model_exec(C_READ, 1, 64'd0, 64'd0, 64'd0);
    checks++;
    if (bus.rocc_resp_valid !== 1'b1 || bus.rocc_resp_bits_data !== exp) begin
      errors++;
      $display("FAIL back_to_back: valid=%b data=%h, required 1 data=%h",
               bus.rocc_resp_valid, bus.rocc_resp_bits_data, exp);
    end
    get_resp(0, r, d);
  endtask

  task automatic test_read_backpressure();
    logic [63:0] exp;
    issue(C_READ, 4'd1, 5'd3, 1'b1, 64'd0, 64'd0);
    exp = model_exec(C_READ, 1, 64'd0, 64'd0, 64'd0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.rocc_resp_valid, bus.rocc_cmd_ready, bus.rocc_busy} !== 3'b101 ||
          bus.rocc_resp_bits_data !== exp || bus.rocc_resp_bits_rd !== 5'd3) begin
        errors++;
        $display("FAIL resp_hold[%0d]: valid/ready/busy=%b rd=%0d data=%h, required 101 rd=3 data=%h", c,
                 {bus.rocc_resp_valid, bus.rocc_cmd_ready, bus.rocc_busy}, bus.rocc_resp_bits_rd,
                 bus.rocc_resp_bits_data, exp);
      end
      tick();
    end
    bus.rocc_resp_ready = 1'b1;
    tick();
    bus.rocc_resp_ready = 1'b0;
    checks++;
    if ({bus.rocc_resp_valid, bus.rocc_cmd_ready, bus.rocc_busy} !== 3'b010) begin
      errors++;
      $display("FAIL resp_release: valid/ready/busy=%b, required 010",
               {bus.rocc_resp_valid, bus.rocc_cmd_ready, bus.rocc_busy});
    end
  endtask

  task automatic test_load_nack();
    logic [63:0] exp, d;
    logic [39:0] a;
    logic [4:0]  r;
    mem[40'h80] = 64'h10;
    issue(C_LOAD, 4'd2, 5'd9, 1'b1, 64'h80, 64'd0);
    checks++;
    if (bus.rocc_mem_req_valid !== 1'b1 || bus.rocc_mem_req_bits_addr !== 40'h80 ||
        bus.rocc_mem_req_bits_cmd !== 5'd0 || bus.rocc_mem_req_bits_size !== 2'd3 ||
        bus.rocc_mem_req_bits_tag !== 8'd0) begin
      errors++;
      $display("FAIL load_req: valid=%b addr=%h cmd=%0d size=%0d tag=%0d, required 1 80 0 3 0",
               bus.rocc_mem_req_valid, bus.rocc_mem_req_bits_addr, bus.rocc_mem_req_bits_cmd,
               bus.rocc_mem_req_bits_size, bus.rocc_mem_req_bits_tag);
    end
    serve_mem(1'b1, 1, a);
    checks++;
    if (a !== 40'h80) begin
      errors++;
      $display("FAIL replay_addr: addr=%h, required 80", a);
    end
    exp = model_exec(C_LOAD, 2, 64'h80, 64'd0, 64'h10);
    get_resp(0, r, d);
    checks++;
    if (r !== 5'd9 || d !== exp) begin
      errors++;
      $display("FAIL load_resp: rd=%0d data=%h, required rd=9 data=%h", r, d, exp);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] exp, d;
    logic [4:0]  r;
    issue(C_SET, 4'd0, 5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    exp = model_exec(C_SET, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    issue(C_ADD, 4'd0, 5'd1, 1'b1, 64'd1, 64'd0);
    exp = model_exec(C_ADD, 0, 64'd1, 64'd0, 64'd0);
    get_resp(1, r, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL ovf_wrap: data=%h, required %h", d, exp);
    end
    repeat (3) tick();
    checks++;
    if (bus.rocc_interrupt !== exp_irq()) begin
      errors++;
      $display("FAIL ovf_irq: interrupt=%b, required %b", bus.rocc_interrupt, exp_irq());
    end
    issue(C_CLEAR, 4'd0, 5'd1, 1'b1, 64'd0, 64'd0);
    exp = model_exec(C_CLEAR, 0, 64'd0, 64'd0, 64'd0);
    get_resp(0, r, d);
    tick();
    checks++;
    if (d !== exp || bus.rocc_interrupt !== exp_irq()) begin
      errors++;
      $display("FAIL clear: data=%h interrupt=%b, required %h %b", d, bus.rocc_interrupt, exp, exp_irq());
    end
  endtask

  task automatic test_exception();
    logic [63:0] exp, d;
    logic [4:0]  r;
    issue(C_SET, 4'd3, 5'd0, 1'b0, 64'h1234, 64'd0);
    exp = model_exec(C_SET, 3, 64'h1234, 64'd0, 64'd0);
    issue(C_LOAD, 4'd3, 5'd4, 1'b1, 64'h100, 64'd0);
    checks++;
    if (bus.rocc_mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL exc_req: mem_req_valid=%b, required 1", bus.rocc_mem_req_valid);
    end
    bus.rocc_mem_req_ready = 1'b1;
    tick();
    bus.rocc_mem_req_ready = 1'b0;
    bus.rocc_exception = 1'b1;
    tick();
    bus.rocc_exception = 1'b0;
    checks++;
    if ({bus.rocc_busy, bus.rocc_resp_valid, bus.rocc_mem_req_valid, bus.rocc_cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL exc_abort: busy/resp/req/ready=%b, required 0001",
               {bus.rocc_busy, bus.rocc_resp_valid, bus.rocc_mem_req_valid, bus.rocc_cmd_ready});
    end
    bus.rocc_mem_resp_valid = 1'b1;
    bus.rocc_mem_resp_bits_tag = '0;
    bus.rocc_mem_resp_bits_data = 64'h55;
    tick();
    bus.rocc_mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.rocc_resp_valid !== 1'b0 || bus.rocc_busy !== 1'b0) begin
        errors++;
        $display("FAIL exc_late_resp[%0d]: resp_valid=%b busy=%b, required 0 0", c,
                 bus.rocc_resp_valid, bus.rocc_busy);
      end
      tick();
    end
    issue(C_READ, 4'd3, 5'd4, 1'b1, 64'd0, 64'd0);
    exp = model_exec(C_READ, 3, 64'd0, 64'd0, 64'd0);
    get_resp(0, r, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL exc_acc: acc3=%h, required %h", d, exp);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [63:0] exp, d, v;
    logic [4:0]  r;
    for (int i = 0; i < int'(NUM_ACC); i++) begin
      v = rnd64();
      issue(C_SET, 4'(i), 5'd0, 1'b0, v, 64'd0);
      exp = model_exec(C_SET, i, v, 64'd0, 64'd0);
    end
    issue(C_READ, 4'd2, 5'd5, 1'b1, 64'd0, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (bus.rocc_resp_valid !== 1'b0 || bus.rocc_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_resp: resp_valid=%b busy=%b, required 0 0", bus.rocc_resp_valid, bus.rocc_busy);
    end
    for (int i = 0; i < int'(NUM_ACC); i++) begin
      issue(C_READ, 4'(i), 5'(i), 1'b1, 64'd0, 64'd0);
      exp = model_exec(C_READ, i, 64'd0, 64'd0, 64'd0);
      get_resp(0, r, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL reset_acc[%0d]: data=%h, required %h", i, d, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [3:0]  fhi;
    logic [4:0]  rd, r;
    logic        xd;
    logic [63:0] rs1, rs2, exp, d;
    logic [39:0] a;
    int unsigned idx;
    for (int k = 0; k < 80; k++) begin
      op  = 3'($urandom_range(0, 7));
      fhi = 4'($urandom_range(0, 15));
      idx = int'(fhi) % NUM_ACC;
      rd  = 5'($urandom_range(0, 31));
      xd  = 1'($urandom_range(0, 1));
      rs1 = (op == C_LOAD) ? 64'($urandom_range(0, 15)) << 3 : rnd64();
      rs2 = rnd64();
      issue(op, fhi, rd, xd, rs1, rs2);
      if (op == C_LOAD) begin
        serve_mem($urandom_range(0, 3) == 0, $urandom_range(0, 3), a);
        checks++;
        if (a !== rs1[39:0]) begin
          errors++;
          $display("FAIL rnd_addr[%0d]: addr=%h, required %h", k, a, rs1[39:0]);
        end
      end
      exp = model_exec(op, idx, rs1, rs2, (op == C_LOAD) ? mem_lookup(rs1[39:0]) : 64'd0);
      if (xd) begin
        get_resp($urandom_range(0, 2), r, d);
        checks++;
        if (r !== rd || d !== exp) begin
          errors++;
          $display("FAIL rnd_resp[%0d]: op=%0d idx=%0d rd=%0d data=%h, required rd=%0d data=%h",
                   k, op, idx, r, d, rd, exp);
        end
      end else begin
        checks++;
        if (bus.rocc_resp_valid !== 1'b0 || bus.rocc_busy !== 1'b0) begin
          errors++;
          $display("FAIL rnd_noresp[%0d]: resp_valid=%b busy=%b, required 0 0", k,
                   bus.rocc_resp_valid, bus.rocc_busy);
        end
      end
      checks++;
      if (bus.rocc_interrupt !== exp_irq()) begin
        errors++;
        $display("FAIL rnd_irq[%0d]: interrupt=%b, required %b", k, bus.rocc_interrupt, exp_irq());
      end
    end
  endtask

  initial begin
    bus.rocc_cmd_valid = 1'b0;
    bus.rocc_cmd_bits_inst_funct = '0;
    bus.rocc_cmd_bits_inst_rd = '0;
    bus.rocc_cmd_bits_inst_xd = 1'b0;
    bus.rocc_cmd_bits_rs1 = '0;
    bus.rocc_cmd_bits_rs2 = '0;
    bus.rocc_resp_ready = 1'b0;
    bus.rocc_mem_req_ready = 1'b0;
    bus.rocc_mem_s2_nack = 1'b0;
    bus.rocc_mem_resp_valid = 1'b0;
    bus.rocc_mem_resp_bits_tag = '0;
    bus.rocc_mem_resp_bits_data = '0;
    bus.rocc_exception = 1'b0;
    model_reset();
    test_reset();
    test_set_add();
    test_read_backpressure();
    test_load_nack();
    test_overflow();
    test_exception();
    test_reset_in_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
